// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, byte-lane
// constants and the address fault decode used on every access.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    localparam int BYTE_OFF_MSB = 1;
    localparam int BYTE_OFF_LSB = 0;

    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / 8;
    localparam int CNT_W  = 4;

    // A byte address faults if it is not word aligned or lies beyond the array.
    function automatic logic addr_fault(input logic [31:0] addr, input int addr_width);
        logic [31:0] upper;
        upper = addr >> (addr_width + 2);
        return (addr[BYTE_OFF_MSB:BYTE_OFF_LSB] != 2'b00) || (upper != 32'd0);
    endfunction

endpackage

// File: rtl/data_mem_responder_be_ram_array.sv
// Word array with per-byte-lane write enables, combinational read and an
// asynchronous clear of every word.
module be_ram_array
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  we,
    input  logic [LANES-1:0]      be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int n = 0; n < LANES; n++) begin
                if (be[n]) begin
                    mem[addr][8*n +: 8] <= wdata[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: accepts one request, waits WAIT_STATES
// cycles, then performs the load/store and pulses o_ack (with o_err on faults).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [31:0]       i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [LANES-1:0]  i_be,
    output logic              o_ready,
    output logic              o_ack,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_err
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;

    logic               req_we;
    logic [31:0]        req_addr;
    logic [WORD_W-1:0]  req_wdata;
    logic [LANES-1:0]   req_be;

    logic               acc_we;
    logic [31:0]        acc_addr;
    logic [WORD_W-1:0]  acc_wdata;
    logic [LANES-1:0]   acc_be;

    logic               fire;
    logic               acc_err;
    logic               ram_we;
    logic [WORD_W-1:0]  ram_rdata;

    // With zero wait states the access happens on the accept edge itself, so
    // the live request fields must be used instead of the captured copy.
    always_comb begin
        acc_we    = req_we;
        acc_addr  = req_addr;
        acc_wdata = req_wdata;
        acc_be    = req_be;
        if (state == S_IDLE) begin
            acc_we    = i_we;
            acc_addr  = i_addr;
            acc_wdata = i_wdata;
            acc_be    = i_be;
        end
    end

    assign fire    = (WAIT_STATES == 0) ? ((state == S_IDLE) && i_req)
                                        : ((state == S_WAIT) && (wait_cnt == WAIT_LAST));
    assign acc_err = addr_fault(acc_addr, ADDR_WIDTH);
    assign ram_we  = fire && acc_we && !acc_err;
    assign o_ready = (state == S_IDLE);

    be_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (i_clk),
        .arst_n (i_arst),
        .we     (ram_we),
        .be     (acc_be),
        .addr   (acc_addr[ADDR_WIDTH+1:2]),
        .wdata  (acc_wdata),
        .rdata  (ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            o_ack     <= 1'b0;
            o_err     <= 1'b0;
            o_rdata   <= '0;
        end else begin
            o_ack <= fire;
            o_err <= fire && acc_err;
            // Load data is held until the next load completes; stores leave it alone.
            if (fire && !acc_we) begin
                o_rdata <= acc_err ? '0 : ram_rdata;
            end

            unique case (state)
                S_IDLE: begin
                    if (i_req) begin
                        req_we    <= i_we;
                        req_addr  <= i_addr;
                        req_wdata <= i_wdata;
                        req_be    <= i_be;
                        wait_cnt  <= WAIT_INIT;
                        state     <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder with two instances (2 and 0 wait
// states) checked against an array-based memory model.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];

    logic        ready0, ack0, err0, ready1, ack1, err1;
    logic [31:0] rdata0, rdata1;

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut_ws2 (
        .i_clk(clk), .i_arst(arst), .i_req(req[0]), .i_we(we[0]), .i_addr(addr[0]),
        .i_wdata(wdata[0]), .i_be(be[0]), .o_ready(ready0), .o_ack(ack0),
        .o_rdata(rdata0), .o_err(err0));

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_ws0 (
        .i_clk(clk), .i_arst(arst), .i_req(req[1]), .i_we(we[1]), .i_addr(addr[1]),
        .i_wdata(wdata[1]), .i_be(be[1]), .o_ready(ready1), .o_ack(ack1),
        .o_rdata(rdata1), .o_err(err1));

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model   [2][DEPTH];
    logic [31:0] last_rd [2];
    time         last_acc[2];
    int          acc_cnt [2];
    int          ack_cnt [2];

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction
    function automatic logic get_ready(input int d);
        return (d == 0) ? ready0 : ready1;
    endfunction
    function automatic logic get_ack(input int d);
        return (d == 0) ? ack0 : ack1;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? err0 : err1;
    endfunction
    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? rdata0 : rdata1;
    endfunction

    always @(posedge clk) begin
        if (ack0) ack_cnt[0] <= ack_cnt[0] + 1;
        if (ack1) ack_cnt[1] <= ack_cnt[1] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) model[d][i] = '0;
            last_rd[d] = '0;
        end
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= 32'(4 * DEPTH));
    endfunction

    // Issue one request from the current negedge and follow it to its ack.
    task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b,
                          input bit toggle, input bit b2b);
        int   lat;
        bit   seen;
        logic e;
        time  acc_t;
        int   idx;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        for (int k = 0; k < 8 && !get_ready(d); k++) @(negedge clk);
        check("ready_before_accept", 32'(get_ready(d)), 32'd1);
        @(posedge clk);
        acc_t = $time;
        if (b2b) check("b2b_spacing", int'((acc_t - last_acc[d]) / 10), ws_of(d) + 2);
        last_acc[d] = acc_t;
        acc_cnt[d]++;
        e = is_bad(a);
        idx = int'(a[AW+1:2]);
        if (!e && w) begin
            for (int n = 0; n < 4; n++)
                if (b[n]) model[d][idx][8*n +: 8] = wd[8*n +: 8];
        end
        if (!w) last_rd[d] = e ? 32'd0 : model[d][idx];
        seen = 0;
        lat  = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (get_ack(d)) seen = 1;
            else begin
                check("ready_busy", 32'(get_ready(d)), 32'd0);
                if (toggle) begin
                    addr[d]  = addr[d] ^ 32'h0000_0044;
                    wdata[d] = ~wdata[d];
                    be[d]    = ~be[d];
                    we[d]    = ~we[d];
                end
            end
        end
        check("ack_seen", 32'(seen), 32'd1);
        check("ack_latency", lat, ws_of(d) + 1);
        check("err", 32'(get_err(d)), 32'(e));
        check("rdata", get_rdata(d), last_rd[d]);
    endtask

    task automatic idle(input int d);
        req[d] = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(get_ack(d)), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return 32'(4 * DEPTH) + ($urandom & 32'h00ff_fffc);
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    initial begin
        arst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; we[d] = 0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
            last_acc[d] = 0; acc_cnt[d] = 0; ack_cnt[d] = 0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", 32'(get_ready(d)), 32'd1);
            check("reset_ack",   32'(get_ack(d)),   32'd0);
            check("reset_err",   32'(get_err(d)),   32'd0);
            check("reset_rdata", get_rdata(d),      32'd0);
        end
        arst = 1'b1;
        @(negedge clk);

        // Full word, byte lane, empty lane mask, halfword lanes.
        do_txn(0, 1, 32'h10, 32'hDEADBEEF, BE_WORD, 0, 0); idle(0);
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, 0);           idle(0);
        check("rd_deadbeef", last_rd[0], 32'hDEADBEEF);
        do_txn(0, 1, 32'h10, 32'h000000AA, 4'b0001, 0, 0); idle(0);
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, 0);           idle(0);
        do_txn(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, 0); idle(0);
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, 0);           idle(0);
        do_txn(0, 1, 32'h14, 32'h11223344, BE_HALF_LO, 0, 0); idle(0);
        do_txn(0, 1, 32'h14, 32'h55667788, BE_HALF_HI, 0, 0); idle(0);
        do_txn(0, 0, 32'h14, 32'h0, 4'h0, 0, 0);           idle(0);

        // Faulting addresses, then a store to one must not touch memory.
        do_txn(0, 0, 32'h12, 32'h0, 4'h0, 0, 0);           idle(0);
        do_txn(0, 0, 32'h400, 32'h0, 4'h0, 0, 0);          idle(0);
        do_txn(0, 1, 32'h412, 32'hCAFEF00D, BE_WORD, 0, 0); idle(0);
        do_txn(0, 1, 32'h11, 32'hCAFEF00D, BE_WORD, 0, 0); idle(0);
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, 0);           idle(0);

        // Request fields change during WAIT; the captured address must be used.
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 1, 0);
        do_txn(0, 0, 32'h14, 32'h0, 4'h0, 1, 1);           idle(0);

        // Reset in WAIT discards the pending store.
        req[0] = 1; we[0] = 1; addr[0] = 32'h20; wdata[0] = 32'h12345678; be[0] = BE_WORD;
        check("rst_pre_ready", 32'(ready0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("rst_wait_ready", 32'(ready0), 32'd0);
        arst = 1'b0;
        #1;
        check("rst_async_ready", 32'(ready0), 32'd1);
        req[0] = 0;
        repeat (3) @(negedge clk);
        check("rst_no_ack", 32'(ack0), 32'd0);
        check("rst_rdata", rdata0, 32'd0);
        arst = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_post_ready", 32'(ready0), 32'd1);
        do_txn(0, 0, 32'h20, 32'h0, 4'h0, 0, 0);           idle(0);
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, 0);           idle(0);

        // Zero wait states, back-to-back.
        do_txn(1, 1, 32'h40, 32'hA5A5A5A5, BE_WORD, 0, 0);
        do_txn(1, 1, 32'h44, 32'h5A5A5A5A, BE_WORD, 0, 1);
        do_txn(1, 0, 32'h40, 32'h0, 4'h0, 0, 1);
        do_txn(1, 0, 32'h44, 32'h0, 4'h0, 0, 1);
        do_txn(1, 0, 32'h46, 32'h0, 4'h0, 0, 1);           idle(1);

        // Random traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 120; i++) begin
                bit b2b;
                b2b = (i > 0) && ($urandom_range(0, 1) == 1);
                if (!b2b) begin
                    if (i > 0) idle(d);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                do_txn(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                       4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, b2b);
            end
            idle(d);
        end

        @(negedge clk);
        check("ack_count_ws2", ack_cnt[0], acc_cnt[0]);
        check("ack_count_ws0", ack_cnt[1], acc_cnt[1]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the processor's data-memory port, with multi-cycle, handshaked load/store servicing, so the CPU core can move to a stalled or multi-cycle datapath.
- Accepts one request at a time, inserts a configurable number of wait states, then performs the access and pulses an acknowledge.
- Provides word storage with byte-lane write enables, and error flagging for misaligned or out-of-range byte addresses.

Parameters:
- ADDR_WIDTH, 8, word-address bits; depth = 2^ADDR_WIDTH 32-bit words (1 KiB at the default).
- WAIT_STATES, 2, idle cycles inserted between accept and access; legal range 0..15.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_arst  input  1  reset, asynchronous, active-low.
- i_req  input  1  request valid; sampled only when o_ready=1.
- i_we  input  1  1 = store, 0 = load; qualified by i_req.
- i_addr  input  32  byte address, from the ALU result.
- i_wdata  input  32  store data.
- i_be  input  4  byte-lane enables for stores; bit n enables bits [8n+7:8n]. Ignored for loads.
- o_ready  output  1  responder can accept a request this cycle.
- o_ack  output  1  one-cycle pulse: access complete.
- o_rdata  output  32  load data; valid while o_ack=1, held until the next load ack.
- o_err  output  1  qualifies o_ack: the request was misaligned or out of range.

Behaviour:
- Reset (i_arst=0, asynchronous):
  - State = IDLE, wait counter = 0, all captured request registers = 0.
  - o_ack=0, o_err=0, o_rdata=0, all memory words = 0.
  - o_ready=1 combinationally from IDLE, but i_req is not sampled while reset is asserted.
- FSM states: IDLE, WAIT, RESP, encoded in 2 bits. o_ready = (state==IDLE).
- IDLE:
  - On a rising edge with i_req=1, capture i_we, i_addr, i_wdata and i_be.
  - Load the counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, otherwise go to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 1, the next edge goes to RESP.
  - Exactly WAIT_STATES cycles are spent in WAIT.
- Entering RESP (same edge):
  - Store: write only the enabled byte lanes of word addr[ADDR_WIDTH+1:2]. i_be=0000 writes nothing but still acks.
  - Load: o_rdata is set to the full word.
  - o_ack=1 for one cycle in RESP, o_err valid in the same cycle.
- RESP goes to IDLE unconditionally on the next edge; o_ack and o_err return to 0.
- Latency: accept edge to o_ack high = WAIT_STATES+1 cycles. Minimum request spacing = WAIT_STATES+2 cycles.
- Initiator rule: hold i_req and all request fields until o_ack. Changes to inputs after capture have no effect. i_req while o_ready=0 is ignored, not queued.
- Error cases:
  - Conditions: i_addr[1:0]!=0, or i_addr[31:ADDR_WIDTH+2]!=0.
  - No memory update, load returns o_rdata=0, o_err=1 with o_ack.
  - Timing is identical to a good access.
- Read-after-write: a load issued after a store's ack returns the updated data. There is no internal forwarding case, because only one request is in flight.
- Reset asserted in WAIT or RESP: the pending store is discarded, no ack is produced, and all state returns to reset values.
- Counter width: 4 bits. Arithmetic never wraps, because the counter is loaded nonzero only when WAIT is entered.

Decomposition:
- Shared include mips_mem_defs.vh holds:
  - FSM state encodings S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2.
  - Byte-enable constants BE_WORD=4'b1111, BE_HALF_LO=4'b0011, BE_HALF_HI=4'b1100.
  - Byte-offset field position (addr[1:0]).
- One natural sub-module, be_ram_array: a word array with asynchronous clear and per-lane write enable, instantiated with ADDR_WIDTH.
- The FSM, counter and error decode live in the top module.

Test Plan:
- Reset then store 0xDEADBEEF to 0x10, be=1111, WAIT_STATES=2 -> o_ack rises 3 cycles after accept, o_err=0; load from 0x10 returns 0xDEADBEEF.
- Byte-lane store 0x000000AA to 0x10 with be=0001 over 0xDEADBEEF -> following load returns 0xDEADBEAA; be=0000 store -> data unchanged, ack still pulses.
- Load from 0x12 (misaligned) and from 0x400 (out of range, ADDR_WIDTH=8) -> o_ack with o_err=1, o_rdata=0, memory unchanged.
- i_req held high continuously during a load, with i_addr toggled during WAIT -> exactly one ack per accepted request, data from the captured address, o_ready=0 in WAIT/RESP.
- Reset pulsed during WAIT of a store of 0x12345678 to 0x20 -> no ack; after release, o_ready=1 and a load from 0x20 returns 0.
- Rebuild with WAIT_STATES=0 -> ack on the cycle after accept, and back-to-back requests spaced 2 cycles apart are all served.
